// File: rtl/fano_pkg.sv
// Shared convolutional-code constants and frame-state encoding for the
// K=7 rate-1/2 encoder and its matching Fano decoder.
package fano_pkg;

  localparam int unsigned K_DEF  = 7;
  localparam logic [6:0]  G0_DEF = 7'o171;
  localparam logic [6:0]  G1_DEF = 7'o133;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/conv_encoder_parity.sv
// Single parity tap: XOR of the encoder window masked by a generator polynomial.
module conv_parity #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] window,
  input  logic [W-1:0] poly,
  output logic         parity
);

  assign parity = ^(window & poly);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail termination and a
// ready/valid handshake on both the information and rib sides.
module conv_encoder
  import fano_pkg::*;
#(
  parameter int unsigned K  = K_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_vld,
  input  logic       i_bit,
  input  logic       i_last,
  output logic       o_rdy,
  output logic       o_vld,
  output logic [1:0] o_rib,
  output logic       o_last,
  input  logic       i_rdy,
  output logic       o_busy
);

  localparam logic [2:0] TAIL_LAST = 3'(K - 2);

  enc_state_e   state_q, state_d;
  logic [K-2:0] s_q, s_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [1:0]   rib_q, rib_d;
  logic         vld_q, vld_d;
  logic         last_q, last_d;

  logic         adv;
  logic         in_xfer;
  logic         d0;
  logic [K-1:0] window;
  logic         par_g0, par_g1;

  // Window MSB is the current bit so poly bit K-1-k lines up with dk.
  assign d0     = (state_q == ST_TAIL) ? 1'b0 : i_bit;
  assign window = {d0, s_q};

  conv_parity #(.W(K)) u_par_g0 (.window(window), .poly(G0), .parity(par_g0));
  conv_parity #(.W(K)) u_par_g1 (.window(window), .poly(G1), .parity(par_g1));

  assign adv     = !vld_q || i_rdy;
  assign o_rdy   = reset_n && (state_q != ST_TAIL) && adv;
  assign in_xfer = i_vld && o_rdy;

  assign o_vld  = vld_q;
  assign o_rib  = rib_q;
  assign o_last = last_q;
  // Busy persists after the FSM returns to IDLE until the o_last rib leaves.
  assign o_busy = (state_q != ST_IDLE) || (vld_q && last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      rib_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rib_q   <= rib_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rib_d   = rib_q;
    vld_d   = vld_q;
    last_d  = last_q;

    if (vld_q && i_rdy) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (in_xfer) begin
          rib_d   = {par_g0, par_g1};
          s_d     = {d0, s_q[K-2:1]};
          vld_d   = 1'b1;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = i_last ? ST_TAIL : ST_DATA;
        end
      end
      ST_TAIL: begin
        if (adv) begin
          rib_d  = {par_g0, par_g1};
          s_d    = {d0, s_q[K-2:1]};
          vld_d  = 1'b1;
          last_d = (cnt_q == TAIL_LAST);
          if (cnt_q == TAIL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder against a direct convolution model.
module tb_conv_encoder;

  localparam int unsigned K  = 7;
  localparam logic [6:0]  G0 = 7'o171;
  localparam logic [6:0]  G1 = 7'o133;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_vld = 1'b0, i_bit = 1'b0, i_last = 1'b0, i_rdy = 1'b1;
  logic       o_rdy, o_vld, o_last, o_busy;
  logic [1:0] o_rib;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int stall_cnt = 0;

  logic [2:0] got_q[$];
  int         got_t[$];
  logic [2:0] exp_q[$];
  bit         in_bits[$];
  bit         in_lasts[$];
  logic [2:0] imp[7];

  logic       prev_stall = 1'b0;
  logic [1:0] prev_rib;
  logic       prev_last;

  always #5 clk = ~clk;

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_bit(i_bit), .i_last(i_last),
    .o_rdy(o_rdy), .o_vld(o_vld), .o_rib(o_rib), .o_last(o_last),
    .i_rdy(i_rdy), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (rdy_mode)
      0:       i_rdy = 1'b1;
      1:       i_rdy = (cyc % 3 == 0);
      default: i_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("hold_vld", o_vld, 1);
        check("hold_rib", o_rib, prev_rib);
        check("hold_last", o_last, prev_last);
      end
      if (o_vld && !i_rdy) check("rdy_low_stall", o_rdy, 0);
      if (o_vld && i_rdy) begin
        got_q.push_back({o_last, o_rib});
        got_t.push_back(cyc);
      end
      prev_stall = o_vld && !i_rdy;
      prev_rib   = o_rib;
      prev_last  = o_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Expected ribs from the generator definition: each output is the
  // convolution of the frame (zero-padded by K-1) with G0 and G1.
  function automatic void build_exp();
    int start;
    int len;
    logic p0, p1;
    exp_q.delete();
    start = 0;
    for (int i = 0; i < in_bits.size(); i++) begin
      if (in_lasts[i]) begin
        len = i - start + 1;
        for (int n = 0; n < len + int'(K) - 1; n++) begin
          p0 = 1'b0;
          p1 = 1'b0;
          for (int k = 0; k < int'(K); k++) begin
            if (n - k >= 0 && n - k < len && in_bits[start + n - k]) begin
              p1 ^= G0[int'(K) - 1 - k];
              p0 ^= G1[int'(K) - 1 - k];
            end
          end
          exp_q.push_back({(n == len + int'(K) - 2), p1, p0});
        end
        start = i + 1;
      end
    end
  endfunction

  task automatic feed();
    int budget;
    stall_cnt = 0;
    for (int i = 0; i < in_bits.size(); i++) begin
      i_vld  = 1'b1;
      i_bit  = in_bits[i];
      i_last = in_lasts[i];
      budget = 200;
      @(negedge clk);
      while (!o_rdy && budget > 0) begin
        stall_cnt++;
        budget--;
        @(negedge clk);
      end
      if (budget == 0) check("feed_timeout", 0, 1);
      @(posedge clk); #1;
    end
    i_vld  = 1'b0;
    i_bit  = 1'($urandom);
    i_last = 1'($urandom);
  endtask

  task automatic drain(input string tag);
    int budget = 5000;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check({tag, "_drain_timeout"}, 0, 1);
    repeat (4) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_rib"}, got_q[i], exp_q[i]);
    check({tag, "_busy_end"}, o_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_impulse(input string tag);
    check({tag, "_imp_count"}, got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      check({tag, "_imp_rib"}, got_q[i], imp[i]);
  endtask

  task automatic new_run();
    got_q.delete();
    got_t.delete();
    in_bits.delete();
    in_lasts.delete();
  endtask

  initial begin
    int n;
    imp = '{3'b011, 3'b010, 3'b011, 3'b011, 3'b000, 3'b001, 3'b111};

    // Reset state
    #12;
    check("rst_vld", o_vld, 0);
    check("rst_rib", o_rib, 0);
    check("rst_last", o_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rdy", o_rdy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_rdy", o_rdy, 1);

    // Impulse, always ready: seven consecutive ribs
    new_run();
    rdy_mode = 0;
    in_bits.push_back(1'b1); in_lasts.push_back(1'b1);
    build_exp();
    feed();
    check("imp_busy_tail", o_busy, 1);
    drain("imp");
    check_impulse("imp");
    if (got_t.size() == 7) check("imp_consec", got_t[6] - got_t[0], 6);

    // All-zero 10-bit frame
    new_run();
    for (int i = 0; i < 10; i++) begin
      in_bits.push_back(1'b0);
      in_lasts.push_back(i == 9);
    end
    build_exp();
    feed();
    drain("zero");
    check("zero_count16", got_q.size(), 16);
    if (got_q.size() == 16) check("zero_last16", got_q[15], 3'b100);

    // Impulse under 1,0,0 backpressure
    new_run();
    rdy_mode = 1;
    in_bits.push_back(1'b1); in_lasts.push_back(1'b1);
    build_exp();
    feed();
    drain("bp");
    check_impulse("bp");

    // 1000-bit random frame then a 20-bit frame with i_vld held high
    new_run();
    rdy_mode = 0;
    for (int i = 0; i < 1000; i++) begin
      in_bits.push_back(1'($urandom));
      in_lasts.push_back(i == 999);
    end
    in_bits[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_bits.push_back(1'($urandom));
      in_lasts.push_back(i == 19);
    end
    build_exp();
    feed();
    check("stream_tail_rdy_low", stall_cnt, 6);
    drain("stream");
    if (got_t.size() == 1032) begin
      check("stream_rate1", got_t[1005] - got_t[0], 1005);
      check("stream_rate2", got_t[1031] - got_t[1006], 25);
    end

    // Several random frames under random backpressure
    new_run();
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        in_bits.push_back(1'($urandom));
        in_lasts.push_back(i == n - 1);
      end
    end
    build_exp();
    feed();
    drain("rand");

    // Reset in the middle of the tail
    new_run();
    rdy_mode = 0;
    in_bits.push_back(1'b1); in_lasts.push_back(1'b1);
    feed();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_vld", o_vld, 0);
    check("midrst_last", o_last, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_rdy", o_rdy, 0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    new_run();
    in_bits.push_back(1'b1); in_lasts.push_back(1'b1);
    build_exp();
    feed();
    drain("postrst");
    check_impulse("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter G0, default 7'o171, meaning generator polynomial for rib bit 1.
REQ-002 SHALL have parameter G1, default 7'o133, meaning generator polynomial for rib bit 0.
REQ-003 SHALL have parameter K, default 7, meaning constraint length; the tail length is K-1.
REQ-004 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_vld  input  1  an information bit is offered.
REQ-007 i_bit  input  1  information bit.
REQ-008 i_last  input  1  marks the final information bit of the frame; qualified by i_vld.
REQ-009 o_rdy  output  1  the block accepts an information bit this cycle.
REQ-010 o_vld  output  1  o_rib is valid.
REQ-011 o_rib  output  2  encoded rib {g0 parity, g1 parity}, matching the decoder rib format.
REQ-012 o_last  output  1  marks the final tail rib of the frame.
REQ-013 i_rdy  input  1  downstream accepts the rib.
REQ-014 o_busy  output  1  a frame is in progress (state DATA or TAIL).

Function
REQ-015 An input transfer SHALL occur when i_vld, o_rdy and reset_n are all high; an output transfer SHALL occur when o_vld and i_rdy are both high.
REQ-016 The state machine SHALL have states IDLE, DATA and TAIL. IDLE goes to DATA on a transfer without i_last. IDLE or DATA goes to TAIL on a transfer with i_last. TAIL goes to IDLE when the last tail rib is loaded into the output register.
REQ-017 o_rdy SHALL be high only in IDLE or DATA, and only when (!o_vld | i_rdy).
REQ-018 The encoder state s[K-2:0] SHALL hold past bits, with d1 the newest and d6 the oldest; d0 is the current bit.
REQ-019 Rib bit 1 SHALL be the XOR over k=0..6 of (G0[6-k] & dk); rib bit 0 SHALL be the same using G1.
REQ-020 On every input transfer, the block SHALL load the computed rib into the output register, shift d0 into s, and set o_vld high on the next cycle. Latency is 1 cycle.
REQ-021 In TAIL, the block SHALL generate K-1 ribs with d0=0, one per cycle in which (!o_vld | i_rdy). A 3-bit tail counter SHALL count 0..K-2.
REQ-022 o_last SHALL be high only with the (K-1)th tail rib; s SHALL be all-zero after the tail.
REQ-023 While o_vld & !i_rdy, o_rib, o_last and o_vld SHALL hold stable, and s and the state SHALL not advance.
REQ-024 o_vld SHALL drop the cycle after an output transfer when no new rib is loaded. Back-to-back operation SHALL sustain 1 rib per cycle with i_rdy held high.
REQ-025 A one-bit frame (i_last on the first bit) SHALL produce exactly 1+(K-1) ribs.
REQ-026 i_bit and i_last SHALL be ignored when no input transfer occurs.
REQ-027 o_busy SHALL be high from the first input transfer of a frame until the o_last rib is transferred.

Reset
REQ-028 While reset_n is low, the block SHALL force state=IDLE, s=0, tail counter=0, o_vld=0, o_rib=0, o_last=0 and o_busy=0; o_rdy SHALL be low.
REQ-029 Reset mid-frame SHALL discard the partial frame with no o_last; the first frame after release SHALL encode from the zero state.

Structure
REQ-030 The default values of G0, G1 and K, and the state encoding, SHALL reside in a shared package fano_pkg, for reuse by the decoder.
REQ-031 Parity generation SHALL be one combinational sub-module, conv_parity (inputs: window, poly; output: 1 bit), instantiated twice.

Verification
REQ-032 Impulse test: a single bit 1 with i_last, and i_rdy=1, SHALL produce ribs 11,10,11,11,00,01,11 on consecutive cycles, with o_last on the 7th only.
REQ-033 All-zero test: a 10-bit all-zero frame SHALL produce 16 ribs of 00, with o_last on the 16th.
REQ-034 Backpressure test: the impulse frame with i_rdy toggling 1,0,0,1,... SHALL produce the identical rib sequence, with o_rib stable while stalled and o_rdy low while o_vld&!i_rdy.
REQ-035 Streaming test: a 1000-bit random frame with i_rdy=1 and i_vld=1 SHALL give one transfer per cycle, and ribs SHALL match a software K=7 171/133 model; o_rdy SHALL be low for exactly 6 tail cycles.
REQ-036 Reset test: asserting reset_n=0 mid-TAIL SHALL clear o_vld and o_last immediately; after release, a new impulse frame SHALL again give 11,10,11,11,00,01,11.
REQ-037 Frame-boundary test: i_vld held high across two frames SHALL show that no bit is accepted during TAIL, and the second frame SHALL start from the zero state.
